bus_frame_scheduler: RTL and testbench

- Round-robin scheduler for the shared single-wire node bus: arbitrates the 16 node send requests (mod).
- Latches the winner's receiver address, data and CRC, then serialises one frame onto bus_show.
- Sits between the per-node register banks and the bus_show line; only one node drives the bus at a time.

---
 rtl/bus_pkg.sv | 22 ++
 rtl/bus_frame_scheduler_if.sv | 30 +++
 rtl/bus_frame_scheduler_rr_arbiter_16.sv | 37 +++
 rtl/bus_frame_scheduler.sv | 117 +++++++++++
 tb/tb_bus_frame_scheduler.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/bus_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bus_pkg: shared sizes and state encoding for the bus frame scheduler |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package bus_pkg;

   localparam int N_NODES   = 16;
   localparam int ADDR_W    = 4;
   localparam int DATA_W    = 64;
   localparam int CRC_W     = 4;
   localparam int FRAME_LEN = 1 + 2 * ADDR_W + DATA_W + CRC_W;
   localparam int CNT_W     = 7;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      GAP  = 2'd2
   } state_t;

endpackage
`default_nettype wire

// File: rtl/bus_frame_scheduler_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bus_frame_scheduler_if: node request fields and serial bus outputs   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface bus_frame_scheduler_if;
   import bus_pkg::*;

   logic [N_NODES-1:0]        mod;
   logic [N_NODES*ADDR_W-1:0] receiver_addr_flat;
   logic [N_NODES*DATA_W-1:0] data_flat;
   logic [N_NODES*CRC_W-1:0]  crc_flat;
   logic                      bus_show;
   logic [N_NODES-1:0]        grant;
   logic [N_NODES-1:0]        ack;
   logic                      busy;
   logic                      frame_done;

   modport master (
      output mod, receiver_addr_flat, data_flat, crc_flat,
      input  bus_show, grant, ack, busy, frame_done
   );

   modport slave (
      input  mod, receiver_addr_flat, data_flat, crc_flat,
      output bus_show, grant, ack, busy, frame_done
   );

endinterface
`default_nettype wire

// File: rtl/bus_frame_scheduler_rr_arbiter_16.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rr_arbiter_16: rotate-priority pick starting just after last_grant   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module rr_arbiter_16
   import bus_pkg::*;
(
   input  logic [N_NODES-1:0] req,
   input  logic [ADDR_W-1:0]  last_grant,
   output logic               valid,
   output logic [ADDR_W-1:0]  idx,
   output logic [N_NODES-1:0] onehot
);

   logic [ADDR_W-1:0] cand;

   // Scan from the farthest candidate down so the nearest one after last_grant wins.
   always_comb begin
      valid  = 1'b0;
      idx    = '0;
      onehot = '0;
      cand   = '0;
      for (int k = N_NODES; k >= 1; k--) begin
         cand = last_grant + ADDR_W'(k);
         if (req[cand]) begin
            valid = 1'b1;
            idx   = cand;
         end
      end
      if (valid) begin
         onehot[idx] = 1'b1;
      end
   end

endmodule
`default_nettype wire

// File: rtl/bus_frame_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bus_frame_scheduler: round-robin arbitration and frame serialiser    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module bus_frame_scheduler
   import bus_pkg::*;
(
   input  logic                  clock,
   input  logic                  reset,
   bus_frame_scheduler_if.slave  bus
);

   state_t                 state_q, state_d;
   logic [FRAME_LEN-1:0]   sr_q, sr_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [ADDR_W-1:0]      last_grant_q, last_grant_d;
   logic                   bus_show_q, bus_show_d;
   logic [N_NODES-1:0]     grant_q, grant_d;
   logic [N_NODES-1:0]     ack_q, ack_d;
   logic                   busy_q, busy_d;
   logic                   frame_done_q, frame_done_d;

   logic                   arb_valid;
   logic [ADDR_W-1:0]      arb_idx;
   logic [N_NODES-1:0]     arb_onehot;
   logic [FRAME_LEN-1:0]   new_frame;

   rr_arbiter_16 u_arb (
      .req        (bus.mod),
      .last_grant (last_grant_q),
      .valid      (arb_valid),
      .idx        (arb_idx),
      .onehot     (arb_onehot)
   );

   assign new_frame = {1'b1, arb_idx,
                       bus.receiver_addr_flat[arb_idx*ADDR_W +: ADDR_W],
                       bus.data_flat[arb_idx*DATA_W +: DATA_W],
                       bus.crc_flat[arb_idx*CRC_W +: CRC_W]};

   // The start bit goes straight to bus_show at the latch edge; sr holds the remainder.
   always_comb begin
      state_d      = state_q;
      sr_d         = sr_q;
      cnt_d        = cnt_q;
      last_grant_d = last_grant_q;
      bus_show_d   = 1'b0;
      grant_d      = grant_q;
      ack_d        = '0;
      frame_done_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (arb_valid) begin
               sr_d         = {new_frame[FRAME_LEN-2:0], 1'b0};
               bus_show_d   = new_frame[FRAME_LEN-1];
               grant_d      = arb_onehot;
               ack_d        = arb_onehot;
               last_grant_d = arb_idx;
               cnt_d        = '0;
               state_d      = SEND;
            end
         end
         SEND: begin
            if (cnt_q == CNT_W'(FRAME_LEN - 1)) begin
               grant_d = '0;
               state_d = GAP;
            end else begin
               bus_show_d   = sr_q[FRAME_LEN-1];
               sr_d         = {sr_q[FRAME_LEN-2:0], 1'b0};
               cnt_d        = cnt_q + 1'b1;
               frame_done_d = (cnt_q == CNT_W'(FRAME_LEN - 2));
            end
         end
         GAP: begin
            state_d = IDLE;
         end
         default: begin
            grant_d = '0;
            state_d = IDLE;
         end
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         sr_q         <= '0;
         cnt_q        <= '0;
         last_grant_q <= ADDR_W'(N_NODES - 1);
         bus_show_q   <= 1'b0;
         grant_q      <= '0;
         ack_q        <= '0;
         busy_q       <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         sr_q         <= sr_d;
         cnt_q        <= cnt_d;
         last_grant_q <= last_grant_d;
         bus_show_q   <= bus_show_d;
         grant_q      <= grant_d;
         ack_q        <= ack_d;
         busy_q       <= busy_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign bus.bus_show   = bus_show_q;
   assign bus.grant      = grant_q;
   assign bus.ack        = ack_q;
   assign bus.busy       = busy_q;
   assign bus.frame_done = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_bus_frame_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_bus_frame_scheduler: directed self-checking bench                 |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_bus_frame_scheduler;
   import bus_pkg::*;

   logic clock = 1'b0;
   logic reset = 1'b1;
   int   n_checks = 0;
   int   n_fail   = 0;
   int   cyc      = 0;

   bus_frame_scheduler_if bif ();

   bus_frame_scheduler dut (
      .clock (clock),
      .reset (reset),
      .bus   (bif)
   );

   always #5 clock = ~clock;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [FRAME_LEN-1:0] exp_frame(input logic [3:0] s, input logic [3:0] r,
                                                      input logic [63:0] d, input logic [3:0] c);
      return {1'b1, s, r, d, c};
   endfunction

   task automatic tick();
      @(posedge clock);
      #1;
      cyc++;
   endtask

   task automatic set_node(input int i, input logic [3:0] r, input logic [63:0] d, input logic [3:0] c);
      bif.receiver_addr_flat[i*ADDR_W +: ADDR_W] = r;
      bif.data_flat[i*DATA_W +: DATA_W]          = d;
      bif.crc_flat[i*CRC_W +: CRC_W]             = c;
   endtask

   task automatic do_reset();
      bif.mod                = '0;
      bif.receiver_addr_flat = '0;
      bif.data_flat          = '0;
      bif.crc_flat           = '0;
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic wait_ack(input int limit, output bit ok, output int waited);
      waited = 0;
      while (bif.ack == '0 && waited < limit) begin
         tick();
         waited++;
      end
      ok = (bif.ack != '0);
   endtask

   // Called in the start-bit cycle; collects all frame bits MSB first.
   task automatic capture(output logic [FRAME_LEN-1:0] cap, output int done_cnt, output int done_pos);
      cap      = {{(FRAME_LEN-1){1'b0}}, bif.bus_show};
      done_cnt = (bif.frame_done === 1'b1) ? 1 : 0;
      done_pos = (bif.frame_done === 1'b1) ? 0 : -1;
      for (int i = 1; i < FRAME_LEN; i++) begin
         tick();
         cap = {cap[FRAME_LEN-2:0], bif.bus_show};
         if (bif.frame_done === 1'b1) begin
            done_cnt++;
            done_pos = i;
         end
      end
   endtask

   task automatic test_reset();
      bif.mod                = 16'hFFFF;
      bif.receiver_addr_flat = '0;
      bif.data_flat          = '0;
      bif.crc_flat           = '0;
      reset = 1'b1;
      tick();
      tick();
      n_checks++; if (bif.bus_show !== 1'b0) begin n_fail++; $display("FAIL reset_bus_show: got %b want 0", bif.bus_show); end
      n_checks++; if (bif.grant !== 16'h0) begin n_fail++; $display("FAIL reset_grant: got %h want 0000", bif.grant); end
      n_checks++; if (bif.ack !== 16'h0) begin n_fail++; $display("FAIL reset_ack: got %h want 0000", bif.ack); end
      n_checks++; if (bif.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bif.busy); end
      n_checks++; if (bif.frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_frame_done: got %b want 0", bif.frame_done); end
      bif.mod = '0;
      reset = 1'b0;
   endtask

   task automatic test_single();
      bit ok; int waited; int dc; int dp;
      logic [FRAME_LEN-1:0] cap;
      do_reset();
      set_node(0, 4'd1, 64'd1, 4'd1);
      bif.mod = 16'h0001;
      wait_ack(10, ok, waited);
      n_checks++; if (!ok || waited != 1) begin n_fail++; $display("FAIL single_latency: ok=%0b waited %0d want 1", ok, waited); end
      n_checks++; if (bif.ack !== 16'h0001 || bif.grant !== 16'h0001) begin n_fail++; $display("FAIL single_ack_grant: ack %h grant %h want 0001", bif.ack, bif.grant); end
      n_checks++; if (bif.busy !== 1'b1) begin n_fail++; $display("FAIL single_busy: got %b want 1", bif.busy); end
      bif.mod = 16'h0000;
      capture(cap, dc, dp);
      n_checks++; if (cap !== exp_frame(4'd0, 4'd1, 64'd1, 4'd1)) begin n_fail++; $display("FAIL single_frame: got %h want %h", cap, exp_frame(4'd0, 4'd1, 64'd1, 4'd1)); end
      n_checks++; if (dc != 1 || dp != FRAME_LEN-1) begin n_fail++; $display("FAIL single_frame_done: count %0d pos %0d want 1 at 76", dc, dp); end
      tick();
      n_checks++; if (bif.bus_show !== 1'b0 || bif.grant !== 16'h0 || bif.busy !== 1'b1 || bif.frame_done !== 1'b0) begin
         n_fail++; $display("FAIL single_gap: bus %b grant %h busy %b done %b want 0 0000 1 0", bif.bus_show, bif.grant, bif.busy, bif.frame_done);
      end
      tick();
      n_checks++; if (bif.busy !== 1'b0) begin n_fail++; $display("FAIL single_idle_busy: got %b want 0", bif.busy); end
   endtask

   task automatic test_round_robin();
      bit ok; int waited; int dc; int dp; int prev; int idx;
      logic [FRAME_LEN-1:0] cap;
      logic [15:0] want;
      do_reset();
      set_node(0, 4'h3, 64'h0123_4567_89AB_CDEF, 4'h9);
      set_node(1, 4'hC, 64'hFEDC_BA98_7654_3210, 4'h6);
      bif.mod = 16'h0003;
      prev = 0;
      for (int f = 0; f < 3; f++) begin
         idx  = (f == 1) ? 1 : 0;
         want = (f == 1) ? 16'h0002 : 16'h0001;
         wait_ack(100, ok, waited);
         n_checks++; if (!ok || bif.grant !== want || bif.ack !== want) begin
            n_fail++; $display("FAIL rr_grant%0d: ok=%0b grant %h ack %h want %h", f, ok, bif.grant, bif.ack, want);
         end
         if (f > 0) begin
            n_checks++; if (cyc - prev != 79) begin n_fail++; $display("FAIL rr_period%0d: got %0d want 79", f, cyc - prev); end
         end
         prev = cyc;
         capture(cap, dc, dp);
         n_checks++; if (idx == 1 && cap !== exp_frame(4'd1, 4'hC, 64'hFEDC_BA98_7654_3210, 4'h6) ||
                         idx == 0 && cap !== exp_frame(4'd0, 4'h3, 64'h0123_4567_89AB_CDEF, 4'h9)) begin
            n_fail++; $display("FAIL rr_frame%0d: got %h for node %0d", f, cap, idx);
         end
      end
      bif.mod = '0;
   endtask

   task automatic test_wrap();
      bit ok; int waited; int dc; int dp;
      logic [FRAME_LEN-1:0] cap;
      do_reset();
      set_node(15, 4'hA, 64'hDEAD_BEEF_0000_0015, 4'h5);
      bif.mod = 16'h8000;
      wait_ack(10, ok, waited);
      n_checks++; if (!ok || bif.ack !== 16'h8000) begin n_fail++; $display("FAIL wrap_first: ok=%0b ack %h want 8000", ok, bif.ack); end
      bif.mod = 16'h8001;
      capture(cap, dc, dp);
      n_checks++; if (cap !== exp_frame(4'd15, 4'hA, 64'hDEAD_BEEF_0000_0015, 4'h5)) begin
         n_fail++; $display("FAIL wrap_frame15: got %h want %h", cap, exp_frame(4'd15, 4'hA, 64'hDEAD_BEEF_0000_0015, 4'h5));
      end
      wait_ack(100, ok, waited);
      n_checks++; if (!ok || bif.ack !== 16'h0001 || bif.grant !== 16'h0001) begin
         n_fail++; $display("FAIL wrap_next: ok=%0b ack %h grant %h want 0001", ok, bif.ack, bif.grant);
      end
      bif.mod = '0;
   endtask

   task automatic test_midframe_change();
      bit ok; int waited; int dc; int extra;
      logic [FRAME_LEN-1:0] cap;
      do_reset();
      set_node(0, 4'd1, 64'd1, 4'd1);
      bif.mod = 16'h0001;
      wait_ack(10, ok, waited);
      n_checks++; if (!ok || bif.ack !== 16'h0001) begin n_fail++; $display("FAIL mid_ack: ok=%0b ack %h want 0001", ok, bif.ack); end
      cap = {{(FRAME_LEN-1){1'b0}}, bif.bus_show};
      dc  = 0;
      for (int i = 1; i < FRAME_LEN; i++) begin
         if (i == 21) begin
            bif.data_flat[63:0] = 64'hFFFF_FFFF_FFFF_FFFF;
            bif.mod[0]          = 1'b0;
         end
         tick();
         cap = {cap[FRAME_LEN-2:0], bif.bus_show};
         if (bif.frame_done === 1'b1) dc++;
      end
      n_checks++; if (cap !== exp_frame(4'd0, 4'd1, 64'd1, 4'd1) || dc != 1) begin
         n_fail++; $display("FAIL mid_frame: got %h done %0d want %h done 1", cap, dc, exp_frame(4'd0, 4'd1, 64'd1, 4'd1));
      end
      extra = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (bif.ack != '0) extra++;
      end
      n_checks++; if (extra != 0) begin n_fail++; $display("FAIL mid_no_rearb: got %0d acks want 0", extra); end
   endtask

   task automatic test_reset_midframe();
      bit ok; int waited; int dc;
      do_reset();
      set_node(0, 4'hF, 64'hFFFF_FFFF_FFFF_FFFF, 4'hF);
      set_node(1, 4'h2, 64'h5, 4'h3);
      bif.mod = 16'h0001;
      wait_ack(10, ok, waited);
      for (int i = 1; i <= 40; i++) tick();
      n_checks++; if (bif.bus_show !== 1'b1 || bif.grant !== 16'h0001) begin
         n_fail++; $display("FAIL rstmid_pre: bus %b grant %h want 1 0001", bif.bus_show, bif.grant);
      end
      #2;
      reset = 1'b1;
      #1;
      n_checks++; if (bif.bus_show !== 1'b0 || bif.grant !== 16'h0 || bif.busy !== 1'b0) begin
         n_fail++; $display("FAIL rstmid_async: bus %b grant %h busy %b want 0 0000 0", bif.bus_show, bif.grant, bif.busy);
      end
      bif.mod = 16'h0006;
      dc = 0;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (bif.frame_done !== 1'b0) dc++;
      end
      reset = 1'b0;
      waited = 0;
      while (bif.ack == '0 && waited < 10) begin
         tick();
         waited++;
         if (bif.frame_done !== 1'b0) dc++;
      end
      n_checks++; if (bif.ack !== 16'h0002 || bif.grant !== 16'h0002) begin
         n_fail++; $display("FAIL rstmid_winner: ack %h grant %h want 0002", bif.ack, bif.grant);
      end
      n_checks++; if (dc != 0) begin n_fail++; $display("FAIL rstmid_no_done: got %0d pulses want 0", dc); end
      bif.mod = '0;
   endtask

   task automatic test_idle();
      int bad;
      do_reset();
      bad = 0;
      for (int i = 0; i < 200; i++) begin
         tick();
         if (bif.bus_show !== 1'b0 || bif.busy !== 1'b0 || bif.grant !== 16'h0 || bif.ack !== 16'h0) bad++;
      end
      n_checks++; if (bad != 0) begin n_fail++; $display("FAIL idle_quiet: got %0d active cycles want 0", bad); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_wrap();
      test_midframe_change();
      test_reset_midframe();
      test_idle();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
